// File: rtl/elevator_pkg.sv
// Shared types for the elevator scheduler.
// Direction codes, door/lamp levels, panel bit indices, FSM states.
package elevator_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    DOWN   = 2'b01,
    UP     = 2'b10,
    UPDOWN = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    CHECK,
    DOOR
  } state_e;

  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;
  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;

  localparam int OPEN_B  = 9;
  localparam int CLOSE_B = 8;

  // SCAN choice when leaving a stop: keep the
  // current heading if work lies ahead, else turn.
  function automatic dir_e scan_dir(
    input dir_e d,
    input logic above,
    input logic below
  );
    dir_e r;
    r = STOP;
    if (d == DOWN) begin
      if (below)      r = DOWN;
      else if (above) r = UP;
    end else begin
      if (above)      r = UP;
      else if (below) r = DOWN;
    end
    return r;
  endfunction

endpackage

// File: rtl/request_bank.sv
// Latched hall/car requests with per-floor clear and above/below summary.
// Ports: clk, rst_n, set pulses, floor + clear strobes, lamps, above/below.
module request_bank #(
  parameter int BOTTOM = 1,
  parameter int TOP    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TOP:BOTTOM] i_up_set,
  input  logic [TOP:BOTTOM] i_dn_set,
  input  logic [TOP:BOTTOM] i_car_set,
  input  logic [2:0]        i_floor,
  input  logic              i_clr_car,
  input  logic              i_clr_up,
  input  logic              i_clr_dn,
  output logic [TOP:BOTTOM] o_up,
  output logic [TOP:BOTTOM] o_dn,
  output logic [TOP:BOTTOM] o_car,
  output logic              o_above,
  output logic              o_below
);
  import elevator_pkg::*;

  localparam int N = TOP - BOTTOM + 1;

  logic [TOP:BOTTOM] r_up, r_dn, r_car;
  logic [TOP:BOTTOM] w_sel, w_hi, w_lo;
  logic [TOP:BOTTOM] w_up_ok, w_dn_ok, w_any;

  always_comb begin
    w_sel   = '0;
    w_hi    = '0;
    w_lo    = '0;
    w_up_ok = '0;
    w_dn_ok = '0;
    for (int i = BOTTOM; i <= TOP; i++) begin
      w_sel[i]   = int'(i_floor) == i;
      w_hi[i]    = int'(i_floor) < i;
      w_lo[i]    = int'(i_floor) > i;
      // no up call at the top, no down call at the bottom
      w_up_ok[i] = i != TOP;
      w_dn_ok[i] = i != BOTTOM;
    end
  end

  // clear is applied after set so it wins on the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up  <= '0;
      r_dn  <= '0;
      r_car <= '0;
    end else begin
      r_up  <= (r_up | (i_up_set & w_up_ok))
             & ~(w_sel & {N{i_clr_up}});
      r_dn  <= (r_dn | (i_dn_set & w_dn_ok))
             & ~(w_sel & {N{i_clr_dn}});
      r_car <= (r_car | i_car_set)
             & ~(w_sel & {N{i_clr_car}});
    end
  end

  assign w_any   = r_up | r_dn | r_car;
  assign o_above = |(w_any & w_hi);
  assign o_below = |(w_any & w_lo);
  assign o_up    = r_up;
  assign o_dn    = r_dn;
  assign o_car   = r_car;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler and floor-by-floor motion sequencer.
// Ports: clk, reset, enable, calls, doorState in; floor/dir/lamps out.
module elevator_scheduler #(
  parameter int CLK_PER_FLOOR = 3,
  parameter int DOOR_TIMEOUT  = 16,
  parameter int BOTTOM        = 1,
  parameter int TOP           = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [TOP:BOTTOM] hallUp,
  input  logic [TOP:BOTTOM] hallDown,
  input  logic [9:1]        internalButton,
  input  logic              doorState,
  output logic [2:0]        currentFloor,
  output logic [1:0]        currentDirection,
  output logic [1:0]        currentFloorButton,
  output logic              moving,
  output logic [TOP:BOTTOM] carLamp,
  output logic [TOP:BOTTOM] upLamp,
  output logic [TOP:BOTTOM] downLamp
);
  import elevator_pkg::*;

  localparam int CW  = $clog2(CLK_PER_FLOOR + 1);
  localparam int TCW = $clog2(DOOR_TIMEOUT + 1);
  // CHECK is the last tick of each floor, so MOVE
  // runs one tick short of the floor period.
  localparam int LD  =
    (CLK_PER_FLOOR >= 2) ? CLK_PER_FLOOR - 2 : 0;
  localparam logic [CW-1:0] LOAD  = CW'(LD);
  localparam logic [2:0]    BOT_F = 3'(BOTTOM);
  localparam logic [2:0]    TOP_F = 3'(TOP);

  state_e          r_state, w_state_n;
  dir_e            r_dir, w_dir_n, w_exit;
  logic [2:0]      r_floor, w_floor_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [TCW-1:0]  r_tcnt, w_tcnt_n;
  logic            r_seen, w_seen_n;
  logic            w_clr_car, w_clr_up, w_clr_dn;

  logic [TOP:BOTTOM] w_up, w_dn, w_car;
  logic w_above, w_below, w_ahead;
  logic w_here, w_car_f, w_hall_dir;
  logic w_up_hit, w_dn_hit, w_at_end;
  logic w_timeout, w_unused;

  assign w_unused = ^internalButton[OPEN_B:CLOSE_B];

  request_bank #(.BOTTOM(BOTTOM), .TOP(TOP)) u_bank (
    .clk       (clk),
    .rst_n     (reset),
    .i_up_set  (hallUp),
    .i_dn_set  (hallDown),
    .i_car_set (internalButton[TOP:BOTTOM]),
    .i_floor   (r_floor),
    .i_clr_car (w_clr_car),
    .i_clr_up  (w_clr_up),
    .i_clr_dn  (w_clr_dn),
    .o_up      (w_up),
    .o_dn      (w_dn),
    .o_car     (w_car),
    .o_above   (w_above),
    .o_below   (w_below)
  );

  assign w_car_f  = w_car[r_floor];
  assign w_here   = w_car_f | w_up[r_floor]
                  | w_dn[r_floor];
  assign w_up_hit = w_up[r_floor]
                  | (w_car_f & (r_dir != DOWN));
  assign w_dn_hit = w_dn[r_floor]
                  | (w_car_f & (r_dir != UP));
  assign w_ahead  = (r_dir == UP) ? w_above
                                  : w_below;
  assign w_hall_dir = (r_dir == UP)
                    ? w_up[r_floor]
                    : w_dn[r_floor];
  assign w_at_end =
    ((r_dir == UP)   && (r_floor == TOP_F)) ||
    ((r_dir == DOWN) && (r_floor == BOT_F));
  assign w_timeout = !r_seen &&
    (r_tcnt == TCW'(DOOR_TIMEOUT - 1));
  assign w_exit = scan_dir(r_dir, w_above, w_below);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dir   <= STOP;
      r_floor <= BOT_F;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_seen  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_dir   <= w_dir_n;
      r_floor <= w_floor_n;
      r_cnt   <= w_cnt_n;
      r_tcnt  <= w_tcnt_n;
      r_seen  <= w_seen_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_dir_n   = r_dir;
    w_floor_n = r_floor;
    w_cnt_n   = r_cnt;
    w_tcnt_n  = r_tcnt;
    w_seen_n  = r_seen;
    w_clr_car = 1'b0;
    w_clr_up  = 1'b0;
    w_clr_dn  = 1'b0;
    if (enable) begin
      unique case (r_state)
        IDLE: begin
          w_dir_n = STOP;
          if (w_here) begin
            w_state_n = DOOR;
            w_seen_n  = 1'b0;
            w_tcnt_n  = '0;
          end else if (w_above || w_below) begin
            w_dir_n   = w_exit;
            w_state_n = MOVE;
            w_cnt_n   = LOAD;
          end
        end
        MOVE: begin
          if (r_cnt == '0) begin
            w_floor_n = (r_dir == UP)
                      ? r_floor + 3'd1
                      : r_floor - 3'd1;
            w_state_n = CHECK;
          end else begin
            w_cnt_n = r_cnt - CW'(1);
          end
        end
        CHECK: begin
          if (w_car_f || w_hall_dir ||
              !w_ahead || w_at_end) begin
            if (w_here) begin
              w_state_n = DOOR;
              w_seen_n  = 1'b0;
              w_tcnt_n  = '0;
              // only an opposite hall call here
              if (!w_ahead && !w_car_f &&
                  !w_hall_dir)
                w_dir_n = (r_dir == UP) ? DOWN
                                        : UP;
            end else begin
              w_state_n = IDLE;
              w_dir_n   = STOP;
            end
          end else begin
            w_state_n = MOVE;
            w_cnt_n   = LOAD;
          end
        end
        DOOR: begin
          if (doorState == OPEN) begin
            w_seen_n  = 1'b1;
            w_clr_car = 1'b1;
            w_clr_up  = r_dir != DOWN;
            w_clr_dn  = r_dir != UP;
          end
          if (!r_seen)
            w_tcnt_n = r_tcnt + TCW'(1);
          if (w_timeout) begin
            w_clr_car = 1'b1;
            w_clr_up  = 1'b1;
            w_clr_dn  = 1'b1;
          end
          if (w_timeout ||
              (r_seen && doorState == CLOSE &&
               !w_up_hit && !w_dn_hit)) begin
            w_dir_n   = w_exit;
            w_state_n = (w_exit == STOP) ? IDLE
                                         : MOVE;
            w_cnt_n   = LOAD;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  assign moving = (r_state == MOVE) ||
                  (r_state == CHECK);
  assign currentFloor       = r_floor;
  assign currentDirection   = r_dir;
  assign currentFloorButton = moving ? 2'b00
                            : {w_up_hit, w_dn_hit};
  assign carLamp  = w_car;
  assign upLamp   = w_up;
  assign downLamp = w_dn;

endmodule
